sample_fifo: RTL and testbench

//   Synchronous single-clock FIFO directly downstream of funct_generator.

---
 rtl/fifo_defines_pkg.sv | 17 +
 rtl/sample_fifo_if.sv | 30 +++
 rtl/fifo_mem.sv | 31 +++
 rtl/sample_fifo.sv | 92 +++++++++
 tb/tb_sample_fifo.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/fifo_defines_pkg.sv
// Shared sizing and status types for the sample path between funct_generator and its consumer.
package fifo_defines_pkg;

  localparam int unsigned DATA_WIDTH    = 16;
  localparam int unsigned FIFO_DEPTH    = 16;
  localparam int unsigned FIFO_ADDR     = $clog2(FIFO_DEPTH);
  localparam int unsigned FIFO_AF_LEVEL = 12;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/sample_fifo_if.sv
// Handshake and status bundle of sample_fifo; slave is the FIFO, master is the producer/consumer side.
interface sample_fifo_if;
  import fifo_defines_pkg::*;

  logic                         clr_i;
  logic                         wr_en_i;
  logic signed [DATA_WIDTH-1:0] wr_data_i;
  logic                         rd_en_i;
  logic signed [DATA_WIDTH-1:0] rd_data_o;
  logic                         rd_valid_o;
  logic                         full_o;
  logic                         empty_o;
  logic                         almost_full_o;
  logic [FIFO_ADDR:0]           count_o;
  logic                         overflow_o;
  logic                         underflow_o;

  modport slave (
    input  clr_i, wr_en_i, wr_data_i, rd_en_i,
    output rd_data_o, rd_valid_o, full_o, empty_o, almost_full_o, count_o,
           overflow_o, underflow_o
  );

  modport master (
    output clr_i, wr_en_i, wr_data_i, rd_en_i,
    input  rd_data_o, rd_valid_o, full_o, empty_o, almost_full_o, count_o,
           overflow_o, underflow_o
  );

endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port RAM: synchronous write, synchronous read into an output register, no reset.
module fifo_mem #(
  parameter int unsigned  DATA_WIDTH = 16,
  parameter int unsigned  DEPTH      = 16,
  localparam int unsigned ADDR       = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR-1:0]       wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR-1:0]       rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read-before-write on an address collision: the oldest word leaves when full.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sample_fifo.sv
// Single-clock sample FIFO: owns pointers, occupancy, flags and sticky errors around fifo_mem.
module sample_fifo #(
  parameter int unsigned DATA_WIDTH = fifo_defines_pkg::DATA_WIDTH,
  parameter int unsigned DEPTH      = fifo_defines_pkg::FIFO_DEPTH,
  parameter int unsigned AF_LEVEL   = fifo_defines_pkg::FIFO_AF_LEVEL
) (
  input logic          clk,
  input logic          rst,
  sample_fifo_if.slave bus
);
  import fifo_defines_pkg::*;

  localparam int unsigned ADDR = $clog2(DEPTH);
  localparam int unsigned CW   = ADDR + 1;

  logic [ADDR-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  fifo_status_t          status_q, status_d;
  logic                  rd_valid_q;
  logic                  rd_seen_q;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  always_comb begin
    rd_acc = bus.rd_en_i & ~status_q.empty & ~bus.clr_i;
    wr_acc = bus.wr_en_i & (~status_q.full | rd_acc) & ~bus.clr_i;

    count_d = count_q;
    if (bus.clr_i) begin
      count_d = '0;
    end else if (wr_acc && !rd_acc) begin
      count_d = count_q + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - CW'(1);
    end

    // Flags follow the next count so they are registered alongside it.
    status_d.full        = (count_d == CW'(DEPTH));
    status_d.empty       = (count_d == '0);
    status_d.almost_full = (count_d >= CW'(AF_LEVEL));
    status_d.overflow    = ~bus.clr_i & (status_q.overflow | (bus.wr_en_i & ~wr_acc));
    status_d.underflow   = ~bus.clr_i & (status_q.underflow | (bus.rd_en_i & status_q.empty));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      status_q   <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0,
                      overflow: 1'b0, underflow: 1'b0};
      rd_valid_q <= 1'b0;
      rd_seen_q  <= 1'b0;
    end else begin
      count_q    <= count_d;
      status_q   <= status_d;
      rd_valid_q <= rd_acc;
      rd_seen_q  <= rd_seen_q | rd_acc;
      if (bus.clr_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (wr_acc) wr_ptr_q <= wr_ptr_q + ADDR'(1);
        if (rd_acc) rd_ptr_q <= rd_ptr_q + ADDR'(1);
      end
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q),
    .wr_data (bus.wr_data_i),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr_q),
    .rd_data (mem_rd_data)
  );

  // RAM output is unreset; present zero until the first read after reset.
  assign bus.rd_data_o     = rd_seen_q ? mem_rd_data : '0;
  assign bus.rd_valid_o    = rd_valid_q;
  assign bus.count_o       = count_q;
  assign bus.full_o        = status_q.full;
  assign bus.empty_o       = status_q.empty;
  assign bus.almost_full_o = status_q.almost_full;
  assign bus.overflow_o    = status_q.overflow;
  assign bus.underflow_o   = status_q.underflow;

endmodule

// File: tb/tb_sample_fifo.sv
// Scoreboard bench for sample_fifo: reference queue and occupancy model checked every cycle.
module tb_sample_fifo;
  import fifo_defines_pkg::*;

  localparam int DEPTH = FIFO_DEPTH;
  localparam int AF    = FIFO_AF_LEVEL;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sample_fifo_if fifo_bus ();

  sample_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .AF_LEVEL   (FIFO_AF_LEVEL)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (fifo_bus)
  );

  int checks = 0;
  int errors = 0;

  int q[$];
  int m_cnt   = 0;
  bit m_ovf   = 1'b0;
  bit m_unf   = 1'b0;
  bit m_valid = 1'b0;
  int m_last  = 0;
  bit mon_en  = 1'b0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_cnt   = 0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    m_valid = 1'b0;
    m_last  = 0;
  endtask

  // Drive one cycle of stimulus; model and scoreboard advance at the edge.
  task automatic cyc(input bit clr, input bit wr, input int wd, input bit rd);
    bit ra, wa;
    fifo_bus.clr_i     = clr;
    fifo_bus.wr_en_i   = wr;
    fifo_bus.wr_data_i = 16'(wd);
    fifo_bus.rd_en_i   = rd;
    ra = rd && (m_cnt > 0) && !clr;
    wa = wr && ((m_cnt < DEPTH) || ra) && !clr;
    @(posedge clk);
    if (clr) begin
      q.delete();
      m_cnt   = 0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      m_valid = 1'b0;
    end else begin
      if (wr && !wa) m_ovf = 1'b1;
      if (rd && m_cnt == 0) m_unf = 1'b1;
      if (ra) begin
        if (q.size() == 0) check_eq("sb_underrun", 0, 1);
        else m_last = q.pop_front();
      end
      if (wa) q.push_back(wd);
      m_cnt   = m_cnt + int'(wa) - int'(ra);
      m_valid = ra;
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("count", int'(fifo_bus.count_o), m_cnt);
      check_eq("full", int'(fifo_bus.full_o), int'(m_cnt == DEPTH));
      check_eq("empty", int'(fifo_bus.empty_o), int'(m_cnt == 0));
      check_eq("almost_full", int'(fifo_bus.almost_full_o), int'(m_cnt >= AF));
      check_eq("overflow", int'(fifo_bus.overflow_o), int'(m_ovf));
      check_eq("underflow", int'(fifo_bus.underflow_o), int'(m_unf));
      check_eq("rd_valid", int'(fifo_bus.rd_valid_o), int'(m_valid));
      check_eq("rd_data", int'(fifo_bus.rd_data_o), m_last);
    end
  end

  initial begin
    fifo_bus.clr_i     = 1'b0;
    fifo_bus.wr_en_i   = 1'b0;
    fifo_bus.wr_data_i = '0;
    fifo_bus.rd_en_i   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // 1: reset state and underflow on empty read
    cyc(0, 0, 0, 0);
    check_eq("t1_count", int'(fifo_bus.count_o), 0);
    check_eq("t1_empty", int'(fifo_bus.empty_o), 1);
    check_eq("t1_rd_data", int'(fifo_bus.rd_data_o), 0);
    cyc(0, 0, 0, 1);
    check_eq("t1_underflow", int'(fifo_bus.underflow_o), 1);
    check_eq("t1_count_after", int'(fifo_bus.count_o), 0);
    cyc(1, 0, 0, 0);

    // 2: fill, overflow, drain in order
    for (int i = 1; i <= 16; i++) begin
      cyc(0, 1, i, 0);
      if (i == 11) check_eq("t2_af_below", int'(fifo_bus.almost_full_o), 0);
      if (i == 12) check_eq("t2_af_at", int'(fifo_bus.almost_full_o), 1);
    end
    check_eq("t2_full", int'(fifo_bus.full_o), 1);
    cyc(0, 1, 99, 0);
    check_eq("t2_overflow", int'(fifo_bus.overflow_o), 1);
    check_eq("t2_count16", int'(fifo_bus.count_o), 16);
    for (int i = 1; i <= 16; i++) begin
      cyc(0, 0, 0, 1);
      check_eq("t2_rd_valid", int'(fifo_bus.rd_valid_o), 1);
      check_eq("t2_rd_data", int'(fifo_bus.rd_data_o), i);
    end
    check_eq("t2_empty", int'(fifo_bus.empty_o), 1);
    cyc(1, 0, 0, 0);

    // 3: simultaneous read/write while full
    for (int i = 1; i <= 16; i++) cyc(0, 1, i + 20, 0);
    cyc(0, 1, -5, 1);
    check_eq("t3_count", int'(fifo_bus.count_o), 16);
    check_eq("t3_overflow", int'(fifo_bus.overflow_o), 0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 0, 1);
    check_eq("t3_last", int'(fifo_bus.rd_data_o), -5);

    // 4: simultaneous read/write while empty
    cyc(0, 1, 7, 1);
    check_eq("t4_count", int'(fifo_bus.count_o), 1);
    check_eq("t4_underflow", int'(fifo_bus.underflow_o), 1);
    check_eq("t4_no_valid", int'(fifo_bus.rd_valid_o), 0);
    cyc(0, 0, 0, 1);
    check_eq("t4_data", int'(fifo_bus.rd_data_o), 7);
    cyc(1, 0, 0, 0);

    // 5: pointer wrap with interleaved traffic
    for (int i = 0; i < 3; i++) cyc(0, 1, 200 + i, 0);
    for (int i = 0; i < 40; i++) cyc(0, 1, -300 + i * 17, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
    check_eq("t5_errors", int'(fifo_bus.overflow_o | fifo_bus.underflow_o), 0);
    check_eq("t5_empty", int'(fifo_bus.empty_o), 1);

    // 6: clear with pending write, then async reset mid-burst
    for (int i = 0; i < 17; i++) cyc(0, 1, 50 + i, 0);
    for (int i = 0; i < 11; i++) cyc(0, 0, 0, 1);
    check_eq("t6_count5", int'(fifo_bus.count_o), 5);
    check_eq("t6_ovf_set", int'(fifo_bus.overflow_o), 1);
    cyc(1, 1, 123, 0);
    check_eq("t6_clr_count", int'(fifo_bus.count_o), 0);
    check_eq("t6_clr_empty", int'(fifo_bus.empty_o), 1);
    check_eq("t6_clr_ovf", int'(fifo_bus.overflow_o), 0);
    for (int i = 0; i < 6; i++) cyc(0, 1, 400 + i, i > 2);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_eq("t6_rst_count", int'(fifo_bus.count_o), 0);
    check_eq("t6_rst_empty", int'(fifo_bus.empty_o), 1);
    check_eq("t6_rst_valid", int'(fifo_bus.rd_valid_o), 0);
    check_eq("t6_rst_data", int'(fifo_bus.rd_data_o), 0);
    fifo_bus.wr_en_i = 1'b0;
    fifo_bus.rd_en_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(0, 0, 0, 1);
    check_eq("t6_post_rst_unf", int'(fifo_bus.underflow_o), 1);
    cyc(0, 1, 9, 0);
    cyc(0, 0, 0, 1);
    check_eq("t6_post_rst_data", int'(fifo_bus.rd_data_o), 9);
    cyc(0, 0, 0, 0);

    check_eq("sb_drained", q.size(), 0);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
